// File: rtl/multiples_fifo_ctrl.sv
// multiples_fifo_ctrl
//   Self-managed circular FIFO that sits between the multiples generator
//   (producer) and the multiplier datapath (consumer). It owns its read and
//   write pointers, which wrap modulo DEPTH, so DEPTH does not need to be a
//   power of two. The read side is first-word fall-through.
//
// Parameters
//   WIDTH           data width in bits
//   DEPTH           number of storage entries (2 .. 2**ADDR_WIDTH)
//   ADDR_WIDTH      pointer width
//   ALMOST_FULL_LVL count at or above which almost_full asserts (1 .. DEPTH)
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   wr_en        push request
//   wr_data      push data
//   rd_en        pop request
//   rd_data      head-of-queue data (0 when empty)
//   empty        count == 0
//   full         count == DEPTH
//   almost_full  count >= ALMOST_FULL_LVL
//   count        number of stored entries
//   overflow     one-cycle pulse after a rejected push
//   underflow    one-cycle pulse after a rejected pop
//   peek_offset  (MULTIPLES_FIFO_PEEK_EN only) offset from the head
//   peek_data    (MULTIPLES_FIFO_PEEK_EN only) entry at head+offset, 0 if
//                the offset is not below count
//
// Optional feature macro: MULTIPLES_FIFO_PEEK_EN adds the peek port pair.
module multiples_fifo_ctrl #(
   parameter int WIDTH           = 3,
   parameter int DEPTH           = 10,
   parameter int ADDR_WIDTH      = 4,
   parameter int ALMOST_FULL_LVL = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
`ifdef MULTIPLES_FIFO_PEEK_EN
   output logic                  underflow,
   input  logic [ADDR_WIDTH-1:0] peek_offset,
   output logic [WIDTH-1:0]      peek_data
`else
   output logic                  underflow
`endif
);

   localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   AF_CNT    = (ADDR_WIDTH+1)'(ALMOST_FULL_LVL);
   localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH-1);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic                  push_ok, pop_ok;

   // Explicit wrap at DEPTH-1; binary rollover would be wrong for
   // non-power-of-two depths.
   function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign empty       = (count == '0);
   assign full        = (count == DEPTH_CNT);
   assign almost_full = (count >= AF_CNT);

   // A full FIFO can still take a push when the same cycle frees a slot.
   assign pop_ok  = rd_en & ~empty;
   assign push_ok = wr_en & (~full | pop_ok);

   assign rd_data = empty ? '0 : mem[rd_ptr];

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (rst_n && push_ok) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
         if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         overflow  <= wr_en & ~push_ok;
         underflow <= rd_en & ~pop_ok;
      end
   end

`ifdef MULTIPLES_FIFO_PEEK_EN
   // One extra bit holds rd_ptr + offset without loss; a single conditional
   // subtract covers every in-range offset since both terms are < DEPTH.
   logic [ADDR_WIDTH:0]   peek_sum;
   logic [ADDR_WIDTH-1:0] peek_idx;

   always_comb begin
      peek_sum = {1'b0, rd_ptr} + {1'b0, peek_offset};
      if (peek_sum >= DEPTH_CNT) peek_sum = peek_sum - DEPTH_CNT;
      peek_idx = peek_sum[ADDR_WIDTH-1:0];
   end

   assign peek_data = ({1'b0, peek_offset} >= count) ? '0 : mem[peek_idx];
`endif

endmodule

// File: tb/tb_multiples_fifo_ctrl.sv
module tb_multiples_fifo_ctrl;

   localparam int WIDTH = 3;
   localparam int AW    = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            wr_en, rd_en;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] rd_data;
   logic            empty, full, almost_full, overflow, underflow;
   logic [AW:0]     count;
`ifdef MULTIPLES_FIFO_PEEK_EN
   logic [AW-1:0]   peek_offset;
   logic [WIDTH-1:0] peek_data;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   multiples_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(10), .ADDR_WIDTH(AW), .ALMOST_FULL_LVL(8)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data), .empty(empty), .full(full), .almost_full(almost_full),
      .count(count), .overflow(overflow),
`ifdef MULTIPLES_FIFO_PEEK_EN
      .underflow(underflow), .peek_offset(peek_offset), .peek_data(peek_data)
`else
      .underflow(underflow)
`endif
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock with the given request; outputs are sampled 1ns after the edge.
   task automatic cyc(input logic w, input int d, input logic r);
      wr_en   = w;
      wr_data = WIDTH'(d);
      rd_en   = r;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic pop_expect(input string tag, input int v);
      chk(tag, rd_data, v);
      cyc(1'b0, 0, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
`ifdef MULTIPLES_FIFO_PEEK_EN
      peek_offset = '0;
`endif
      cyc(1'b0, 0, 1'b0);
      cyc(1'b0, 0, 1'b0);
      rst_n = 1'b1;
      cyc(1'b0, 0, 1'b0);

      // reset / idle
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_count", count, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_udf", underflow, 0);
      chk("rst_af", almost_full, 0);

      // lone pop on empty
      cyc(1'b0, 0, 1'b1);
      chk("udf_pulse", underflow, 1);
      chk("udf_count", count, 0);
      cyc(1'b0, 0, 1'b0);
      chk("udf_clear", underflow, 0);

      // push 1..7, pop 7
      for (int i = 1; i <= 7; i++) cyc(1'b1, i, 1'b0);
      chk("p7_count", count, 7);
      chk("p7_af", almost_full, 0);
      chk("p7_head", rd_data, 1);
      for (int i = 1; i <= 7; i++) pop_expect("p7_pop", i);
      chk("p7_empty", empty, 1);
      chk("p7_count0", count, 0);

      // fill to full, overflow, drain
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, i % 8, 1'b0);
         chk("fill_af", almost_full, (i + 1) >= 8);
      end
      chk("fill_full", full, 1);
      chk("fill_count", count, 10);
      cyc(1'b1, 5, 1'b0);
      chk("ovf_pulse", overflow, 1);
      chk("ovf_count", count, 10);
      cyc(1'b0, 0, 1'b0);
      chk("ovf_clear", overflow, 0);
      for (int i = 0; i < 10; i++) pop_expect("full_pop", i % 8);
      chk("full_drained", empty, 1);

      // pointer wrap
      for (int i = 1; i <= 6; i++) cyc(1'b1, i, 1'b0);
      for (int i = 1; i <= 6; i++) pop_expect("wrap_pre_pop", i);
      for (int i = 0; i < 8; i++) cyc(1'b1, (i + 3) % 8, 1'b0);
      chk("wrap_count", count, 8);
      for (int i = 0; i < 8; i++) pop_expect("wrap_pop", (i + 3) % 8);
      chk("wrap_empty", empty, 1);

      // simultaneous push+pop at full
      for (int i = 0; i < 10; i++) cyc(1'b1, i % 8, 1'b0);
      cyc(1'b1, 6, 1'b1);
      chk("fullpp_count", count, 10);
      chk("fullpp_ovf", overflow, 0);
      chk("fullpp_full", full, 1);
      for (int i = 1; i < 10; i++) pop_expect("fullpp_pop", i % 8);
      pop_expect("fullpp_last", 6);
      chk("fullpp_empty", empty, 1);

      // simultaneous push+pop at empty
      cyc(1'b1, 4, 1'b1);
      chk("emptypp_udf", underflow, 1);
      chk("emptypp_count", count, 1);
      chk("emptypp_data", rd_data, 4);
      chk("emptypp_nempty", empty, 0);

      // reset mid-stream while pushing
      for (int i = 0; i < 4; i++) cyc(1'b1, i + 1, 1'b0);
      chk("mid_count", count, 5);
      rst_n = 1'b0;
      cyc(1'b1, 7, 1'b0);
      rst_n = 1'b1;
      chk("mid_rst_count", count, 0);
      chk("mid_rst_empty", empty, 1);
      chk("mid_rst_data", rd_data, 0);
      cyc(1'b0, 0, 1'b0);
      chk("mid_rst_idle", count, 0);

`ifdef MULTIPLES_FIFO_PEEK_EN
      for (int i = 2; i <= 4; i++) cyc(1'b1, i, 1'b0);
      peek_offset = 4'd0; #1;
      chk("peek0", peek_data, 2);
      peek_offset = 4'd1; #1;
      chk("peek1", peek_data, 3);
      peek_offset = 4'd2; #1;
      chk("peek2", peek_data, 4);
      peek_offset = 4'd3; #1;
      chk("peek3", peek_data, 0);
      chk("peek_count", count, 3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
